alu_seq: RTL
============

# alu_seq

Parametrised, registered ALU with a start/done handshake and a multi-cycle unsigned multiplier. It supports WIDTH-bit operands, carry-chained add/subtract and rotate-through-carry. The ZCNO flag register updates selectively per operation. It sits in the datapath between the register file and the result bus, and the control unit sequences it by Start/Done.

## Interface
- WIDTH, 8, operand/result width; legal values 4 to 32.
- CLK  in  1  clock; all state changes on rising edge.
- RST_N  in  1  reset; asynchronous and active-low.
- Start  in  1  request; accepted only on an edge where Busy=0.
- FunSel  in  4  operation select; sampled with Start.
- A  in  WIDTH  operand A; sampled with Start.
- B  in  WIDTH  operand B; sampled with Start.
- OutALU  out  WIDTH  registered result; holds until the next completed operation.
- ZCNO  out  4  registered flags: [3]=Z, [2]=C, [1]=N, [0]=O.
- Busy  out  1  high while a MUL is in progress.
- Done  out  1  one-cycle pulse when OutALU/ZCNO have just been updated.

## Operation
- FunSel encoding, the flags each operation writes, and the results. Flags not listed hold their value.
  - 0 A: Z,N.
  - 1 B: Z,N.
  - 2 ~A: Z,N.
  - 3 ~B: Z,N.
  - 4 ADD A+B: Z,C,N,O. C = carry out of bit WIDTH-1.
  - 5 SUB A-B: Z,C,N,O. C = borrow, i.e. 1 when A<B unsigned.
  - 6 ADC A+B+C: Z,C,N,O.
  - 7 SBC A-B-C: Z,C,N,O. C = borrow.
  - 8 AND: Z,N.
  - 9 OR: Z,N.
  - A XOR: Z,N.
  - B LSL A: Z,C,N,O. C=A[W-1]; O=A[W-1]^A[W-2].
  - C LSR A: Z,C,N. C=A[0].
  - D ASR A: Z,C,N. C=A[0]; the MSB is replicated.
  - E CSR A: Z,C,N. Result = {C,A[W-1:1]}; new C=A[0].
  - F MUL: Z,C,N,O. A*B unsigned, multi-cycle. OutALU = low WIDTH bits of the product; C=O=1 if the high WIDTH bits are nonzero.
- Z = (result==0). N = result[W-1].
- O for ADD/ADC and SUB/SBC is two's-complement signed overflow of the full operation, carry-in included.
- ADC/SBC/CSR read the C value registered before the current operation.
- All arithmetic is exactly WIDTH bits; carry/borrow is taken from a WIDTH+1-bit sum.
- States: IDLE, MUL.
  - IDLE plus an accepted Start with FunSel≠F: result and flags written at that edge; stay in IDLE.
  - IDLE plus an accepted Start with FunSel=F: latch A, B and the C-independent context; clear the accumulator and counter; go to MUL.
  - MUL: shift-add one bit per cycle for WIDTH cycles. On the final step write the result and flags and return to IDLE.
- Start with Busy=1 is ignored entirely; operands and FunSel are not re-sampled.
- A and B may change freely after the accepting edge.

## Timing
- Reset (RST_N low, asynchronous):
  - OutALU=0, ZCNO=4'b0000, Busy=0, Done=0.
  - State=IDLE; counter and accumulator cleared.
  - An in-flight MUL is aborted with no Done.
  - Outputs stay at reset values until the first accepted Start after RST_N rises.
- Single-cycle ops: Start accepted at edge k. OutALU/ZCNO are valid after edge k, and Done=1 during cycle k→k+1 only.
- MUL: Start accepted at edge k.
  - Busy=1 after edges k … k+WIDTH-1.
  - At edge k+WIDTH: OutALU/ZCNO are written, Busy→0 and Done→1 for one cycle.
  - Latency is WIDTH cycles.
- Back-to-back operation: a Start is accepted in the same cycle Done is high whenever Busy=0. For single-cycle ops this gives one result per clock, with Done held high continuously.
- Done never asserts without an OutALU/ZCNO update, and an update never occurs without Done.
- OutALU and ZCNO never change while Busy=1.

## Test plan
- Reset, then ADD with A=0x7F, B=0x01 (WIDTH=8). Required: OutALU=0x80, ZCNO=0011, Done high exactly one cycle after the accepting edge, Busy stays 0.
- Carry chain. ADD 0xFF+0x01 → 0x00 with ZCNO=1100. Then ADC 0x10+0x20 → 0x31 with ZCNO=0000. Then SUB 0x05-0x07 → 0xFE with ZCNO=0110. Then SBC 0x10-0x00 → 0x0F with ZCNO=0000.
- MUL 0x0F*0x11. Required: Busy high for 8 cycles, OutALU=0xFF, ZCNO=0010, Done at edge k+8. Then MUL 0x10*0x10 → 0x00 with ZCNO=1101.
- Start pulsed with ADD during an active MUL 0x03*0x05. Required: the ADD is ignored, OutALU stays unchanged until MUL completes with 0x0F, and only one Done pulse occurs.
- RST_N dropped mid-MUL (cycle 4) and asynchronously. Required: all outputs go to 0 immediately, with no Done afterwards. A fresh AND 0xF0&0x3C → 0x30 then works normally.
- CSR with C=1, A=0x02 → 0x81 with ZCNO=0010. Then, on a WIDTH=16 instance, ADD 0xFFFF+0x0001 → 0x0000 with ZCNO=1100, and MUL with Busy high for 16 cycles.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with a Start/Done handshake, selective ZCNO flag updates
// and a WIDTH-cycle shift-add unsigned multiplier.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic [3:0]       FunSel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] OutALU,
  output logic [3:0]       ZCNO,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   out_reg;
  logic [3:0]         zcno_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CW-1:0]      cnt_reg;

  logic               cin;
  logic [WIDTH:0]     ext_next;
  logic [WIDTH-1:0]   res_next;
  logic               c_next;
  logic               o_next;
  logic               wr_c;
  logic               wr_o;
  logic [3:0]         flags_next;

  logic [WIDTH:0]     psum_next;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   prod_lo;
  logic               prod_hi_nz;
  logic [3:0]         mflags_next;

  assign cin = zcno_reg[2];

  always_comb begin
    ext_next = '0;
    res_next = '0;
    c_next   = 1'b0;
    o_next   = 1'b0;
    wr_c     = 1'b0;
    wr_o     = 1'b0;
    case (FunSel)
      4'h0: res_next = A;
      4'h1: res_next = B;
      4'h2: res_next = ~A;
      4'h3: res_next = ~B;
      4'h4, 4'h6: begin
        ext_next = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, (FunSel == 4'h6) & cin};
        res_next = ext_next[WIDTH-1:0];
        c_next   = ext_next[WIDTH];
        o_next   = (A[WIDTH-1] == B[WIDTH-1]) && (res_next[WIDTH-1] != A[WIDTH-1]);
        wr_c     = 1'b1;
        wr_o     = 1'b1;
      end
      4'h5, 4'h7: begin
        // Top bit of the WIDTH+1-bit difference is the borrow.
        ext_next = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, (FunSel == 4'h7) & cin};
        res_next = ext_next[WIDTH-1:0];
        c_next   = ext_next[WIDTH];
        o_next   = (A[WIDTH-1] != B[WIDTH-1]) && (res_next[WIDTH-1] != A[WIDTH-1]);
        wr_c     = 1'b1;
        wr_o     = 1'b1;
      end
      4'h8: res_next = A & B;
      4'h9: res_next = A | B;
      4'hA: res_next = A ^ B;
      4'hB: begin
        res_next = {A[WIDTH-2:0], 1'b0};
        c_next   = A[WIDTH-1];
        o_next   = A[WIDTH-1] ^ A[WIDTH-2];
        wr_c     = 1'b1;
        wr_o     = 1'b1;
      end
      4'hC: begin
        res_next = {1'b0, A[WIDTH-1:1]};
        c_next   = A[0];
        wr_c     = 1'b1;
      end
      4'hD: begin
        res_next = {A[WIDTH-1], A[WIDTH-1:1]};
        c_next   = A[0];
        wr_c     = 1'b1;
      end
      4'hE: begin
        res_next = {cin, A[WIDTH-1:1]};
        c_next   = A[0];
        wr_c     = 1'b1;
      end
      default: res_next = '0;
    endcase
    flags_next = {res_next == '0, wr_c ? c_next : zcno_reg[2],
                  res_next[WIDTH-1], wr_o ? o_next : zcno_reg[0]};
  end

  // acc_reg holds {partial product, remaining multiplier bits}; one bit per cycle.
  always_comb begin
    psum_next   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                  (acc_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
    prod_next   = {psum_next, acc_reg[WIDTH-1:1]};
    prod_lo     = prod_next[WIDTH-1:0];
    prod_hi_nz  = |prod_next[2*WIDTH-1:WIDTH];
    mflags_next = {prod_lo == '0, prod_hi_nz, prod_lo[WIDTH-1], prod_hi_nz};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      out_reg   <= '0;
      zcno_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      mcand_reg <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Start) begin
            if (FunSel == 4'hF) begin
              mcand_reg <= A;
              acc_reg   <= {{WIDTH{1'b0}}, B};
              cnt_reg   <= '0;
              busy_reg  <= 1'b1;
              state_reg <= MUL;
            end else begin
              out_reg  <= res_next;
              zcno_reg <= flags_next;
              done_reg <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_reg <= prod_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH - 1)) begin
            out_reg   <= prod_lo;
            zcno_reg  <= mflags_next;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign OutALU = out_reg;
  assign ZCNO   = zcno_reg;
  assign Busy   = busy_reg;
  assign Done   = done_reg;

endmodule
